alu_stim_checker: RTL and testbench
===================================

ALU_STIM_CHECKER -- requirements
Module: alu_stim_checker

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width of the ALU under test; legal range 4..15.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  run request, sampled only in IDLE.
REQ-005 seed  input  32  LFSR seed, captured on accepted start.
REQ-006 num_vec  input  16  random-vector count, captured on accepted start.
REQ-007 dut_a  output  WIDTH  operand A to ALU under test (registered).
REQ-008 dut_b  output  WIDTH  operand B to ALU under test (registered).
REQ-009 dut_opcode  output  2  ALU opcode: 00 add, 01 sub, 10 and, 11 or (registered).
REQ-010 dut_y  input  WIDTH  ALU result; combinational from dut_a/dut_b/dut_opcode.
REQ-011 dut_zero  input  1  ALU zero flag.
REQ-012 busy  output  1  high in DIR and RND states.
REQ-013 done  output  1  one-cycle pulse at run completion.
REQ-014 mismatch_cnt  output  16  mismatching vectors this run, saturating.
REQ-015 fail_seen  output  1  sticky; a mismatch occurred this run.
REQ-016 fail_a, fail_b, fail_y  output  WIDTH each  first failing vector's operands and observed result.
REQ-017 fail_op  output  2  first failing vector's opcode.

Function
REQ-018 FSM states IDLE, DIR, RND, DONE; IDLE -start-> DIR; DIR -after 12th vector checked, num_vec!=0-> RND, num_vec==0-> DONE; RND -after num_vec-th vector checked-> DONE; DONE -> IDLE unconditionally.
REQ-019 Accepted start (edge in IDLE with start=1): clear mismatch_cnt, fail_seen, fail_*; capture num_vec; load LFSR with seed, or 32'h1 if seed==0; load first directed vector.
REQ-020 start outside IDLE SHALL be ignored, with no effect on state, counters or capture.
REQ-021 Directed order: opcode outer loop 00..11, pair inner loop (0,0), (all-ones,1), (alternating 10..10, alternating 01..01); 12 vectors.
REQ-022 LFSR: 32-bit Galois, per step lfsr = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0); each random vector steps once, then takes a=lfsr[WIDTH-1:0], b=lfsr[2*WIDTH-1:WIDTH], op=lfsr[2*WIDTH+1:2*WIDTH] from the stepped value.
REQ-023 One vector per cycle; each vector is held exactly one cycle and checked at the edge that replaces it.
REQ-024 Golden: add/sub modulo 2^WIDTH, bitwise and/or; expected zero = (golden==0).
REQ-025 Mismatch = (dut_y != golden) OR (dut_zero != expected zero); counted once per vector.
REQ-026 mismatch_cnt increments by 1 per mismatch and holds at 16'hFFFF.
REQ-027 On the first mismatch of a run, latch a/b/op/dut_y into fail_* and set fail_seen; later mismatches SHALL NOT overwrite them.
REQ-028 busy spans exactly 12+num_vec cycles; done is high the cycle after the last check; results hold until the next accepted start.
REQ-029 dut_a/dut_b/dut_opcode SHALL drive zero in IDLE and DONE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and all outputs to zero, including mid-run; no resume after release, and a new start is required.

Verification
REQ-031 Correct ALU model, seed=1, num_vec=1000 -> busy for 1012 cycles, one done pulse, mismatch_cnt=0, fail_seen=0.
REQ-032 Model corrupting to y=00 only for op=11, a=AA, b=55, num_vec=0 -> mismatch_cnt=1, fail_a=AA, fail_b=55, fail_op=11, fail_y=00.
REQ-033 Model with y stuck 00 and zero stuck 1, num_vec=0 -> mismatch_cnt=6, first fail a=AA, b=55, op=00, y=00.
REQ-034 seed=0 vs seed=1 runs -> identical dut_a/dut_b/dut_opcode sequences; start pulsed mid-run -> no effect.
REQ-035 rst_n asserted at vector 500 of 1000 -> outputs 0 asynchronously; new start after release -> fresh 1012-cycle run with cleared counters.

Source files
------------

// File: rtl/alu_stim_checker_if.sv
// ALU-under-test connection bundle.
// Checker side (master): drives a, b, opcode; samples y, zero.
// ALU side (slave): consumes a, b, opcode; returns combinational y and zero flag.
interface alu_stim_checker_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       opcode;  // 00 add, 01 sub, 10 and, 11 or
  logic [WIDTH-1:0] y;
  logic             zero;

  modport master (output a, b, opcode, input y, zero);
  modport slave  (input a, b, opcode, output y, zero);
endinterface

// File: rtl/alu_stim_checker.sv
// Stimulus generator and checker for a small combinational ALU.
// A run applies 12 directed vectors followed by num_vec_i LFSR-driven random vectors,
// one vector per cycle, and compares the ALU response against a built-in golden model.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i            run request (only honoured in idle)
//   seed_i, num_vec_i  LFSR seed and random-vector count, captured on accepted start
//   alu_if             operands/opcode out, result/zero flag in
//   busy_o, done_o     run in progress / one-cycle completion pulse
//   mismatch_cnt_o     saturating mismatch count for the current run
//   fail_seen_o        sticky mismatch flag; fail_*_o hold the first failing vector
module alu_stim_checker #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          seed_i,
  input  logic [15:0]          num_vec_i,
  alu_stim_checker_if.master   alu_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          mismatch_cnt_o,
  output logic                 fail_seen_o,
  output logic [WIDTH-1:0]     fail_a_o,
  output logic [WIDTH-1:0]     fail_b_o,
  output logic [WIDTH-1:0]     fail_y_o,
  output logic [1:0]           fail_op_o
);

  typedef enum logic [1:0] {StIdle, StDir, StRnd, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [1:0]       pair_q;     // directed operand pair index, 0..2
  logic [31:0]      lfsr_q;
  logic [15:0]      num_vec_q;
  logic [15:0]      rnd_cnt_q;  // random vectors issued so far, including the one on the bus
  logic [15:0]      mismatch_cnt_q;
  logic             fail_seen_q;
  logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_y_q;
  logic [1:0]       fail_op_q;
  logic             done_q;

  logic [WIDTH-1:0] golden;
  logic             vec_bad;
  logic [31:0]      lfsr_step;

  // Bit i of the alternating pattern is i[0] ^ lsb, so lsb=0 gives 10..10, lsb=1 gives 01..01.
  function automatic logic [WIDTH-1:0] alt_pat(input logic lsb);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = lsb ^ i[0];
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] dir_a(input logic [1:0] pair);
    unique case (pair)
      2'd0:    return '0;
      2'd1:    return '1;
      default: return alt_pat(1'b0);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] dir_b(input logic [1:0] pair);
    unique case (pair)
      2'd0:    return '0;
      2'd1:    return WIDTH'(1);
      default: return alt_pat(1'b1);
    endcase
  endfunction

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    golden = '0;
    unique case (op_q)
      2'b00: golden = a_q + b_q;
      2'b01: golden = a_q - b_q;
      2'b10: golden = a_q & b_q;
      2'b11: golden = a_q | b_q;
    endcase
    vec_bad = (alu_if.y != golden) || (alu_if.zero != (golden == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      pair_q         <= '0;
      lfsr_q         <= '0;
      num_vec_q      <= '0;
      rnd_cnt_q      <= '0;
      mismatch_cnt_q <= '0;
      fail_seen_q    <= 1'b0;
      fail_a_q       <= '0;
      fail_b_q       <= '0;
      fail_y_q       <= '0;
      fail_op_q      <= '0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The vector on the bus this cycle is checked at the edge that replaces it.
      if ((state_q == StDir || state_q == StRnd) && vec_bad) begin
        if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_q <= mismatch_cnt_q + 16'd1;
        if (!fail_seen_q) begin
          fail_seen_q <= 1'b1;
          fail_a_q    <= a_q;
          fail_b_q    <= b_q;
          fail_y_q    <= alu_if.y;
          fail_op_q   <= op_q;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q        <= StDir;
            mismatch_cnt_q <= '0;
            fail_seen_q    <= 1'b0;
            fail_a_q       <= '0;
            fail_b_q       <= '0;
            fail_y_q       <= '0;
            fail_op_q      <= '0;
            num_vec_q      <= num_vec_i;
            rnd_cnt_q      <= '0;
            lfsr_q         <= (seed_i == 32'h0) ? 32'h1 : seed_i;
            pair_q         <= 2'd0;
            op_q           <= 2'b00;
            a_q            <= dir_a(2'd0);
            b_q            <= dir_b(2'd0);
          end
        end
        StDir: begin
          if (op_q == 2'b11 && pair_q == 2'd2) begin
            if (num_vec_q != 16'd0) begin
              state_q   <= StRnd;
              lfsr_q    <= lfsr_step;
              a_q       <= lfsr_step[WIDTH-1:0];
              b_q       <= lfsr_step[2*WIDTH-1 -: WIDTH];
              op_q      <= lfsr_step[2*WIDTH+1 -: 2];
              rnd_cnt_q <= 16'd1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              a_q     <= '0;
              b_q     <= '0;
              op_q    <= '0;
            end
          end else if (pair_q == 2'd2) begin
            pair_q <= 2'd0;
            op_q   <= op_q + 2'd1;
            a_q    <= dir_a(2'd0);
            b_q    <= dir_b(2'd0);
          end else begin
            pair_q <= pair_q + 2'd1;
            a_q    <= dir_a(pair_q + 2'd1);
            b_q    <= dir_b(pair_q + 2'd1);
          end
        end
        StRnd: begin
          if (rnd_cnt_q == num_vec_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
          end else begin
            lfsr_q    <= lfsr_step;
            a_q       <= lfsr_step[WIDTH-1:0];
            b_q       <= lfsr_step[2*WIDTH-1 -: WIDTH];
            op_q      <= lfsr_step[2*WIDTH+1 -: 2];
            rnd_cnt_q <= rnd_cnt_q + 16'd1;
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  assign alu_if.a       = a_q;
  assign alu_if.b       = b_q;
  assign alu_if.opcode  = op_q;
  assign busy_o         = (state_q == StDir) || (state_q == StRnd);
  assign done_o         = done_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign fail_seen_o    = fail_seen_q;
  assign fail_a_o       = fail_a_q;
  assign fail_b_o       = fail_b_q;
  assign fail_y_o       = fail_y_q;
  assign fail_op_o      = fail_op_q;

endmodule

// File: tb/tb_alu_stim_checker.sv
module tb_alu_stim_checker;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  seed = '0;
  logic [15:0]  num_vec = '0;
  logic         busy, done, fail_seen;
  logic [15:0]  mismatch_cnt;
  logic [W-1:0] fail_a, fail_b, fail_y;
  logic [1:0]   fail_op;

  int n_vec = 0;
  int n_bad = 0;
  int mode = 0;  // 0 correct ALU, 1 corrupt OR of AA/55, 2 y stuck 0 and zero stuck 1

  logic [W-1:0]   m_y;
  logic [17:0]    rec_q[$];
  logic [17:0]    ref_q[$];

  alu_stim_checker_if #(.WIDTH(W)) alu_if ();

  alu_stim_checker #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .seed_i         (seed),
    .num_vec_i      (num_vec),
    .alu_if         (alu_if),
    .busy_o         (busy),
    .done_o         (done),
    .mismatch_cnt_o (mismatch_cnt),
    .fail_seen_o    (fail_seen),
    .fail_a_o       (fail_a),
    .fail_b_o       (fail_b),
    .fail_y_o       (fail_y),
    .fail_op_o      (fail_op)
  );

  always #5 clk = ~clk;

  // ALU under test, with optional planted faults.
  always_comb begin
    m_y = '0;
    case (alu_if.opcode)
      2'b00:   m_y = alu_if.a + alu_if.b;
      2'b01:   m_y = alu_if.a - alu_if.b;
      2'b10:   m_y = alu_if.a & alu_if.b;
      default: m_y = alu_if.a | alu_if.b;
    endcase
    if (mode == 1 && alu_if.opcode == 2'b11 && alu_if.a == 8'hAA && alu_if.b == 8'h55)
      m_y = 8'h00;
    alu_if.y    = m_y;
    alu_if.zero = (m_y == 8'h00);
    if (mode == 2) begin
      alu_if.y    = 8'h00;
      alu_if.zero = 1'b1;
    end
  end

  // Drives one run from a negedge. Samples at each following negedge; optional start
  // pulse at cycle pulse_at, optional asynchronous reset once busy_cycles reaches rst_at.
  task automatic run(input logic [31:0] s, input logic [15:0] nv, input int pulse_at,
                     input int rst_at, output int busy_cycles, output int done_cnt);
    int tail;
    busy_cycles = 0;
    done_cnt    = 0;
    tail        = -1;
    rec_q.delete();
    seed    = s;
    num_vec = nv;
    start   = 1'b1;
    for (int cyc = 0; cyc < int'(nv) + 60; cyc++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        rec_q.push_back({alu_if.opcode, alu_if.a, alu_if.b});
      end
      if (done) begin
        done_cnt++;
        if (tail < 0) tail = 3;
      end
      start = (cyc == pulse_at);
      if (rst_at >= 0 && busy_cycles == rst_at) begin
        #2 rst_n = 1'b0;
        return;
      end
      if (tail == 0) return;
      if (tail > 0) tail--;
    end
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", mismatch_cnt); end
    n_vec++; if (fail_seen !== 1'b0) begin n_bad++; $display("FAIL reset_fail_seen got %b want 0", fail_seen); end
    n_vec++; if ({alu_if.a, alu_if.b, alu_if.opcode} !== 18'd0) begin n_bad++;
      $display("FAIL reset_dut_bus got %h want 0", {alu_if.a, alu_if.b, alu_if.opcode}); end
    n_vec++; if ({fail_a, fail_b, fail_y, fail_op} !== 26'd0) begin n_bad++;
      $display("FAIL reset_fail_regs got %h want 0", {fail_a, fail_b, fail_y, fail_op}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int bc, dc;
    logic [17:0] exp;
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    pa = '{8'h00, 8'hFF, 8'hAA};
    pb = '{8'h00, 8'h01, 8'h55};
    mode = 0;
    run(32'h1, 16'd0, -1, -1, bc, dc);
    n_vec++; if (bc !== 12) begin n_bad++; $display("FAIL dir_busy_cycles got %0d want 12", bc); end
    n_vec++; if (dc !== 1) begin n_bad++; $display("FAIL dir_done_pulses got %0d want 1", dc); end
    n_vec++; if (mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL dir_cnt got %0d want 0", mismatch_cnt); end
    for (int i = 0; i < 12; i++) begin
      exp = {2'(i / 3), pa[i % 3], pb[i % 3]};
      n_vec++;
      if (i >= rec_q.size() || rec_q[i] !== exp) begin n_bad++;
        $display("FAIL dir_vec%0d got %h want %h", i, (i < rec_q.size()) ? rec_q[i] : 18'h0, exp); end
    end
    n_vec++; if ({alu_if.a, alu_if.b, alu_if.opcode} !== 18'd0) begin n_bad++;
      $display("FAIL idle_dut_bus got %h want 0", {alu_if.a, alu_if.b, alu_if.opcode}); end
  endtask

  task automatic test_random_long();
    int bc, dc;
    mode = 0;
    run(32'h1, 16'd1000, -1, -1, bc, dc);
    n_vec++; if (bc !== 1012) begin n_bad++; $display("FAIL rnd_busy_cycles got %0d want 1012", bc); end
    n_vec++; if (dc !== 1) begin n_bad++; $display("FAIL rnd_done_pulses got %0d want 1", dc); end
    n_vec++; if (mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL rnd_cnt got %0d want 0", mismatch_cnt); end
    n_vec++; if (fail_seen !== 1'b0) begin n_bad++; $display("FAIL rnd_fail_seen got %b want 0", fail_seen); end
    // seed 1 steps to 80200003, then C0300002
    n_vec++; if (rec_q[12] !== {2'b00, 8'h03, 8'h00}) begin n_bad++;
      $display("FAIL rnd_vec0 got %h want %h", rec_q[12], {2'b00, 8'h03, 8'h00}); end
    n_vec++; if (rec_q[13] !== {2'b00, 8'h02, 8'h00}) begin n_bad++;
      $display("FAIL rnd_vec1 got %h want %h", rec_q[13], {2'b00, 8'h02, 8'h00}); end
  endtask

  task automatic test_single_fault();
    int bc, dc;
    mode = 1;
    run(32'h1, 16'd0, -1, -1, bc, dc);
    n_vec++; if (mismatch_cnt !== 16'd1) begin n_bad++; $display("FAIL or_fault_cnt got %0d want 1", mismatch_cnt); end
    n_vec++; if (fail_seen !== 1'b1) begin n_bad++; $display("FAIL or_fault_seen got %b want 1", fail_seen); end
    n_vec++; if ({fail_a, fail_b, fail_op, fail_y} !== {8'hAA, 8'h55, 2'b11, 8'h00}) begin n_bad++;
      $display("FAIL or_fault_capture got %h want %h", {fail_a, fail_b, fail_op, fail_y},
               {8'hAA, 8'h55, 2'b11, 8'h00}); end
  endtask

  task automatic test_stuck_fault();
    int bc, dc;
    mode = 2;
    run(32'h1, 16'd0, -1, -1, bc, dc);
    n_vec++; if (mismatch_cnt !== 16'd6) begin n_bad++; $display("FAIL stuck_cnt got %0d want 6", mismatch_cnt); end
    n_vec++; if ({fail_a, fail_b, fail_op, fail_y} !== {8'hAA, 8'h55, 2'b00, 8'h00}) begin n_bad++;
      $display("FAIL stuck_capture got %h want %h", {fail_a, fail_b, fail_op, fail_y},
               {8'hAA, 8'h55, 2'b00, 8'h00}); end
    repeat (4) @(negedge clk);
    n_vec++; if (mismatch_cnt !== 16'd6) begin n_bad++; $display("FAIL stuck_hold got %0d want 6", mismatch_cnt); end
    mode = 0;
  endtask

  task automatic test_seed_zero_and_start_ignore();
    int bc, dc;
    run(32'h1, 16'd20, -1, -1, bc, dc);
    ref_q = rec_q;
    run(32'h0, 16'd20, 15, -1, bc, dc);
    n_vec++; if (bc !== 32) begin n_bad++; $display("FAIL seed0_busy_cycles got %0d want 32", bc); end
    n_vec++; if (dc !== 1) begin n_bad++; $display("FAIL seed0_done_pulses got %0d want 1", dc); end
    n_vec++; if (rec_q.size() !== ref_q.size()) begin n_bad++;
      $display("FAIL seed0_len got %0d want %0d", rec_q.size(), ref_q.size()); end
    for (int i = 0; i < rec_q.size() && i < ref_q.size(); i++) begin
      n_vec++; if (rec_q[i] !== ref_q[i]) begin n_bad++;
        $display("FAIL seed0_vec%0d got %h want %h", i, rec_q[i], ref_q[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    int bc, dc;
    mode = 2;
    run(32'h1, 16'd1000, -1, 512, bc, dc);  // 12 directed + 500 random
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_vec++; if (mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_cnt got %0d want 0", mismatch_cnt); end
    n_vec++; if ({alu_if.a, alu_if.b, alu_if.opcode, fail_seen} !== 19'd0) begin n_bad++;
      $display("FAIL midrst_outputs got %h want 0", {alu_if.a, alu_if.b, alu_if.opcode, fail_seen}); end
    mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_no_resume got %b want 0", busy); end
    run(32'h1, 16'd1000, -1, -1, bc, dc);
    n_vec++; if (bc !== 1012) begin n_bad++; $display("FAIL rerun_busy_cycles got %0d want 1012", bc); end
    n_vec++; if (dc !== 1) begin n_bad++; $display("FAIL rerun_done_pulses got %0d want 1", dc); end
    n_vec++; if (mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL rerun_cnt got %0d want 0", mismatch_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_long();
    test_single_fault();
    test_stuck_fault();
    test_seed_zero_and_start_ignore();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
